lap_recall_controller: RTL
==========================

# lap_recall_controller

Sequences lap capture and recall for the stopwatch and arbitrates the time display between the live timer value and stored lap snapshots. It sits between the stopwatch state controller and timer datapath on one side and the display driver on the other. It consumes the lap/recall key pulse, the timer run and reset commands, and the live BCD time. It produces the BCD value to display plus lap status.

## Interface
- DEPTH, 4: number of lap slots; DEPTH ≥ 1.
- TIME_W, 24: width of the BCD time word (6 digits mm:ss:cc).
- HOLD_TICKS, 200: number of tick_in pulses a freshly captured lap stays on the display; HOLD_TICKS ≥ 1.
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- key_d_pulse  input  1  one-cycle lap/recall key pulse.
- tick_in  input  1  one-cycle timebase enable (100 Hz).
- timer_running_in  input  1  high while the timer is enabled (the stopwatch controller's timer_run_en_out).
- timer_reset_cmd_in  input  1  high while the timer is being cleared (the stopwatch controller's timer_reset_cmd_out).
- time_bcd_in  input  TIME_W  live timer value.
- display_bcd_out  output  TIME_W  value for the display driver.
- lap_index_out  output  clog2(DEPTH+1)  1-based slot currently shown; 0 when showing live time.
- lap_count_out  output  clog2(DEPTH+1)  number of stored laps.
- recall_mode_out  output  1  high in RECALL.
- lap_full_out  output  1  high when lap_count_out == DEPTH.

## Operation
- States: LIVE, HOLD, RECALL.
- Internal registers: lap buffer DEPTH×TIME_W, count, read index, hold counter, snapshot register.
- timer_reset_cmd_in high, any state:
  - count ← 0, state ← LIVE, hold counter ← 0.
  - Overrides key_d_pulse and tick_in in the same cycle.
  - Buffer contents are not cleared.
- LIVE:
  - key_d_pulse with timer_running_in high and count < DEPTH:
    - write time_bcd_in to slot[count] and to the snapshot register;
    - count++;
    - hold counter ← HOLD_TICKS;
    - go to HOLD.
  - key_d_pulse with timer_running_in high and count == DEPTH: ignored, stay in LIVE.
  - key_d_pulse with timer_running_in low and count > 0: read index ← 0, go to RECALL.
  - key_d_pulse with timer_running_in low and count == 0: ignored.
- HOLD:
  - The display shows the snapshot.
  - Each tick_in decrements the hold counter. The tick that takes it from 1 to 0 moves the block to LIVE.
  - key_d_pulse with timer_running_in high and count < DEPTH: capture as in LIVE, reload HOLD_TICKS, stay in HOLD.
  - key_d_pulse when full, or with the timer stopped: ignored.
  - key_d_pulse and tick_in in the same cycle: the capture wins (the counter reloads, no decrement).
- RECALL:
  - The display shows slot[read index].
  - key_d_pulse with read index < count−1: read index++.
  - key_d_pulse with read index == count−1: go to LIVE.
  - timer_running_in high: go to LIVE immediately; key_d_pulse in that cycle is ignored.
- lap_index_out:
  - LIVE: 0.
  - HOLD: the captured slot number (count after the increment).
  - RECALL: read index + 1.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Outputs load at each clk edge from the next-state values:
  - next state LIVE → display_bcd_out = time_bcd_in (1-cycle latency from input);
  - next state HOLD → the snapshot;
  - next state RECALL → slot[next read index].
- Capture edge:
  - samples time_bcd_in in the same cycle as key_d_pulse;
  - display_bcd_out shows that value from the following cycle.
- HOLD lasts exactly HOLD_TICKS tick_in pulses after the last capture. The display returns to live on the edge of the final tick.
- lap_count_out and lap_full_out update on the capture edge. After timer_reset_cmd_in, both read 0 one cycle later.
- reset_n asserted mid-operation clears the state, counters and outputs immediately. The buffer contents are don't-care after reset.

## Structure
- Shared package holds:
  - state encoding constants (LIVE, HOLD, RECALL, 2-bit);
  - TIME_W and DEPTH defaults;
  - the BCD digit count.
- Sub-module lap_buffer: DEPTH×TIME_W register file with one synchronous write port (we, waddr, wdata) and one asynchronous read port.
- The FSM, counters and output registers live in lap_recall_controller.

## Test plan
- Reset: reset_n low → all outputs 0, state LIVE. Release, time_bcd_in=0x000123 → display_bcd_out=0x000123 one cycle later.
- Capture and hold (HOLD_TICKS=3): running, key_d at time 0x001500 → display 0x001500, lap_index 1, lap_count 1. After 3 tick_in pulses, display follows live time and lap_index 0.
- Full and recapture: 4 captures with DEPTH=4 → lap_full_out=1. A 5th key_d is ignored (lap_count stays 4). key_d together with tick_in in HOLD → counter reloaded.
- Recall walk: stop the timer with laps 0x000100, 0x000200, 0x000300 stored. key_d ×4 → display 0x000100/0x000200/0x000300 with lap_index 1/2/3, then live with recall_mode_out 0.
- Recall abort: in RECALL at index 2, timer_running_in rises → next cycle LIVE, lap_index 0, display live.
- Clear priority: timer_reset_cmd_in high in the same cycle as key_d in HOLD → LIVE, lap_count 0, lap_full 0, no capture.

Source files
------------

// File: rtl/lap_recall_controller_pkg.sv
// Shared types and defaults for the stopwatch lap capture / recall block.
package lap_recall_controller_pkg;

    localparam int TIME_W_DEF = 24;
    localparam int DEPTH_DEF  = 4;
    localparam int BCD_DIGITS = TIME_W_DEF / 4;

    typedef enum logic [1:0] {
        ST_LIVE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RECALL = 2'd2
    } lap_state_t;

endpackage

// File: rtl/lap_recall_controller_if.sv
// Key/timer inputs and display/lap-status outputs of the lap recall controller.
interface lap_recall_controller_if
    import lap_recall_controller_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int TIME_W = TIME_W_DEF
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic              key_d_pulse;
    logic              tick_in;
    logic              timer_running_in;
    logic              timer_reset_cmd_in;
    logic [TIME_W-1:0] time_bcd_in;
    logic [TIME_W-1:0] display_bcd_out;
    logic [CW-1:0]     lap_index_out;
    logic [CW-1:0]     lap_count_out;
    logic              recall_mode_out;
    logic              lap_full_out;

    modport master (
        output key_d_pulse, tick_in, timer_running_in, timer_reset_cmd_in, time_bcd_in,
        input  display_bcd_out, lap_index_out, lap_count_out, recall_mode_out, lap_full_out
    );

    modport slave (
        input  key_d_pulse, tick_in, timer_running_in, timer_reset_cmd_in, time_bcd_in,
        output display_bcd_out, lap_index_out, lap_count_out, recall_mode_out, lap_full_out
    );
endinterface

// File: rtl/lap_recall_controller_lap_buffer.sv
// Lap snapshot store: one synchronous write port, one asynchronous read port.
module lap_buffer #(
    parameter int DEPTH  = 4,
    parameter int TIME_W = 24,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [TIME_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [TIME_W-1:0] rdata_o
);
    // Storage is rounded up to a power of two so the slice index is exact width.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);

    logic [TIME_W-1:0] mem_q [2**IW];

    always_ff @(posedge clk) begin
        if (we_i && (waddr_i < DEPTH_C)) begin
            mem_q[waddr_i[IW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = (raddr_i < DEPTH_C) ? mem_q[raddr_i[IW-1:0]] : '0;

endmodule

// File: rtl/lap_recall_controller.sv
// Lap capture / recall sequencer and display arbiter between live time and lap slots.
//
//   state  | meaning
//   LIVE   | display follows time_bcd_in
//   HOLD   | freshly captured lap shown until HOLD_TICKS ticks elapse
//   RECALL | timer stopped, stepping through stored laps with the key
module lap_recall_controller
    import lap_recall_controller_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int TIME_W     = TIME_W_DEF,
    parameter int HOLD_TICKS = 200
) (
    input  logic                   clk,
    input  logic                   reset_n,
    lap_recall_controller_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_C  = HW'(HOLD_TICKS);

    lap_state_t        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     rd_idx_q, rd_idx_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [TIME_W-1:0] snap_q, snap_d;
    logic [TIME_W-1:0] display_q, display_d;
    logic [CW-1:0]     lap_index_q, lap_index_d;
    logic              recall_q, recall_d;
    logic              full_q, full_d;

    logic              buf_we;
    logic [TIME_W-1:0] buf_rdata;
    logic              capture_ok;

    lap_buffer #(
        .DEPTH  (DEPTH),
        .TIME_W (TIME_W),
        .AW     (CW)
    ) u_lap_buffer (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (count_q),
        .wdata_i (bus.time_bcd_in),
        .raddr_i (rd_idx_d),
        .rdata_o (buf_rdata)
    );

    assign capture_ok = bus.key_d_pulse && bus.timer_running_in && (count_q < DEPTH_C);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_idx_d = rd_idx_q;
        hold_d   = hold_q;
        snap_d   = snap_q;
        buf_we   = 1'b0;

        if (bus.timer_reset_cmd_in) begin
            state_d = ST_LIVE;
            count_d = '0;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                ST_LIVE: begin
                    if (capture_ok) begin
                        buf_we  = 1'b1;
                        snap_d  = bus.time_bcd_in;
                        count_d = count_q + CW'(1);
                        hold_d  = HOLD_C;
                        state_d = ST_HOLD;
                    end else if (bus.key_d_pulse && !bus.timer_running_in
                                 && (count_q != '0)) begin
                        rd_idx_d = '0;
                        state_d  = ST_RECALL;
                    end
                end
                ST_HOLD: begin
                    // A capture outranks a coincident tick: reload, no decrement.
                    if (capture_ok) begin
                        buf_we  = 1'b1;
                        snap_d  = bus.time_bcd_in;
                        count_d = count_q + CW'(1);
                        hold_d  = HOLD_C;
                    end else if (bus.tick_in) begin
                        hold_d = (hold_q != '0) ? hold_q - HW'(1) : '0;
                        if (hold_q <= HW'(1)) begin
                            state_d = ST_LIVE;
                        end
                    end
                end
                ST_RECALL: begin
                    if (bus.timer_running_in) begin
                        state_d = ST_LIVE;
                    end else if (bus.key_d_pulse) begin
                        if (rd_idx_q == count_q - CW'(1)) begin
                            state_d = ST_LIVE;
                        end else begin
                            rd_idx_d = rd_idx_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_LIVE;
                end
            endcase
        end
    end

    always_comb begin
        display_d   = bus.time_bcd_in;
        lap_index_d = '0;
        recall_d    = 1'b0;
        full_d      = (count_d == DEPTH_C);
        unique case (state_d)
            ST_HOLD: begin
                display_d   = snap_d;
                lap_index_d = count_d;
            end
            ST_RECALL: begin
                display_d   = buf_rdata;
                lap_index_d = rd_idx_d + CW'(1);
                recall_d    = 1'b1;
            end
            default: begin
                display_d   = bus.time_bcd_in;
                lap_index_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LIVE;
            count_q     <= '0;
            rd_idx_q    <= '0;
            hold_q      <= '0;
            snap_q      <= '0;
            display_q   <= '0;
            lap_index_q <= '0;
            recall_q    <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_idx_q    <= rd_idx_d;
            hold_q      <= hold_d;
            snap_q      <= snap_d;
            display_q   <= display_d;
            lap_index_q <= lap_index_d;
            recall_q    <= recall_d;
            full_q      <= full_d;
        end
    end

    assign bus.display_bcd_out = display_q;
    assign bus.lap_index_out   = lap_index_q;
    assign bus.lap_count_out   = count_q;
    assign bus.recall_mode_out = recall_q;
    assign bus.lap_full_out    = full_q;

endmodule
